sopc_reset_ctrl: RTL and testbench
==================================

# sopc_reset_ctrl

Parametrised reset sequencer for the SOPC top level. It replaces the single fixed-length bench reset with a synthesizable controller. The controller holds all SOPC reset domains for a programmable count after power-on and releases the domains in staged order (CPU core last). It also re-enters reset on an external button request, a CPU software request, or a watchdog timeout, and records the cause.

## Interface
- NUM_DOMAINS, 3: number of reset outputs; domain 0 is released first, domain NUM_DOMAINS-1 last.
- HOLD_CYCLES, 100: clk cycles all domains stay asserted after each reset entry (100 × 10 ns = 1 µs).
- STAGE_GAP, 4: clk cycles between consecutive domain releases; ≥1.
- SYNC_STAGES, 2: synchroniser depth for rst deassertion and ext_rst_req; ≥2.
- WDT_WIDTH, 16: watchdog counter width.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low power-on reset.
- ext_rst_req  in  1  asynchronous, active-high, level-sensitive button request.
- sw_rst_req  in  1  synchronous one-cycle pulse from the CPU.
- wdt_en  in  1  watchdog enable; sampled only in RUN.
- wdt_load  in  WDT_WIDTH  watchdog reload value.
- wdt_kick  in  1  synchronous pulse; reloads the watchdog.
- dom_rst  out  NUM_DOMAINS  active-high domain resets (SOPC convention).
- rst_done  out  1  high while in RUN.
- rst_cause  out  2  cause of last reset entry: 00 POR, 01 EXT, 10 SW, 11 WDT.

## Operation
- Reset values (rst low): dom_rst all 1 (asserted asynchronously), rst_done 0, rst_cause 00, FSM ASSERT, counters 0.
- rst deassertion passes through a SYNC_STAGES flop chain before the FSM leaves reset. ext_rst_req passes through the same depth of synchroniser, giving ext_s.
- FSM states:
  - ASSERT: all dom_rst=1. hold_cnt increments; while ext_s=1, hold_cnt is held at 0. When hold_cnt==HOLD_CYCLES-1, go to RELEASE with stage_cnt=0 and idx=0.
  - RELEASE: dom_rst[idx] is cleared when stage_cnt==0. stage_cnt counts to STAGE_GAP-1, then idx increments. After the last domain is cleared, go to RUN on the following cycle.
  - RUN: rst_done=1. The watchdog is active when wdt_en=1.
- Reset request in any state other than reset: go to ASSERT on the next edge and set all dom_rst=1 on that same edge. hold_cnt is cleared and rst_cause is updated.
- Request priority when requests coincide: EXT > WDT > SW.
- rst_cause is sticky. It changes only on a new reset entry, or returns to 00 on rst.
- Watchdog:
  - The counter loads wdt_load on entry to RUN and on wdt_kick.
  - It decrements each RUN cycle while wdt_en=1, and holds while wdt_en=0.
  - When the counter reaches 0 with wdt_en=1, it raises a WDT request.
  - wdt_load=0 with wdt_en=1 triggers the WDT request on the first RUN cycle.
  - If wdt_kick and expiry occur in the same cycle, the kick wins.
- A request during ASSERT restarts the hold (hold_cnt←0) and updates the cause. A request during RELEASE aborts the release and re-asserts every domain.

## Timing
- Cycle 0 is the first rising edge on which the synchronised rst is high.
- dom_rst[i] falls at edge HOLD_CYCLES + i·STAGE_GAP. rst_done rises one edge after dom_rst[NUM_DOMAINS-1] falls.
- sw_rst_req or WDT expiry at edge t: dom_rst all 1 and rst_cause updated at edge t+1.
- ext_rst_req rising edge: response appears SYNC_STAGES+1 edges later. Release counting begins when ext_s falls.
- All outputs are registered. There is no combinational path from any input to any output except the asynchronous rst→dom_rst path.

## Structure
- Shared package sopc_pkg holds:
  - the rst_cause encodings (CAUSE_POR, CAUSE_EXT, CAUSE_SW, CAUSE_WDT);
  - the FSM state typedef (ST_ASSERT, ST_RELEASE, ST_RUN).
- Sub-module reset_sync: parameterised SYNC_STAGES flop chain. It is instantiated twice, once for rst deassertion and once for ext_rst_req.
- The watchdog counter stays inline.

## Test plan
All scenarios use NUM_DOMAINS=3, HOLD_CYCLES=8, STAGE_GAP=2, SYNC_STAGES=2, clk period 10 ns.
- POR: rst low for 50 ns, then high → dom_rst falls on bits 0, 1, 2 at edges 8, 10, 12; rst_done=1 at edge 13; rst_cause=00.
- SW reset: sw_rst_req pulse in RUN → dom_rst=3'b111 and rst_cause=10 next edge; sequence repeats with identical spacing.
- Watchdog: wdt_en=1, wdt_load=5, no kick → expiry after 5 RUN cycles; rst_cause=11. Kicking every 3 cycles → no reset over 100 cycles.
- EXT held: ext_rst_req high 20 cycles during RELEASE → all domains re-asserted 3 edges after the rise; dom_rst[0] falls 8 edges after ext_s drops; rst_cause=01.
- Simultaneous: sw_rst_req and WDT expiry in the same cycle → rst_cause=11. Kick coinciding with expiry → no reset.
- Mid-sequence POR: rst low at edge 9 → dom_rst=3'b111 asynchronously (before next edge), rst_cause=00; full sequence restarts.

Source files
------------

// File: rtl/sopc_pkg.sv
// Shared types for the SOPC reset sequencer: reset-cause encodings and FSM states.
package sopc_pkg;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'b00,
    CAUSE_EXT = 2'b01,
    CAUSE_SW  = 2'b10,
    CAUSE_WDT = 2'b11
  } cause_e;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'b00,
    ST_RELEASE = 2'b01,
    ST_RUN     = 2'b10
  } state_e;

  // Coincident requests resolve EXT > WDT > SW.
  function automatic cause_e pick_cause(input logic ext, input logic wdt);
    if (ext)      return CAUSE_EXT;
    else if (wdt) return CAUSE_WDT;
    else          return CAUSE_SW;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Multi-flop synchroniser, cleared asynchronously; used for rst deassertion and the button request.
module reset_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sopc_reset_ctrl.sv
// Staged reset sequencer: holds all domains after any reset entry, releases them in order,
// and re-enters reset on button, software or watchdog request while recording the cause.
module sopc_reset_ctrl
  import sopc_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS = 3,
  parameter int unsigned HOLD_CYCLES = 100,
  parameter int unsigned STAGE_GAP   = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WDT_WIDTH   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   ext_rst_req_i,
  input  logic                   sw_rst_req_i,
  input  logic                   wdt_en_i,
  input  logic [WDT_WIDTH-1:0]   wdt_load_i,
  input  logic                   wdt_kick_i,
  output logic [NUM_DOMAINS-1:0] dom_rst_o,
  output logic                   rst_done_o,
  output logic [1:0]             rst_cause_o
);

  localparam int unsigned HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned STAGE_W = (STAGE_GAP > 1)   ? $clog2(STAGE_GAP)   : 1;
  localparam int unsigned IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  logic rst_sync_n;
  logic ext_s;

  reset_sync #(.STAGES(SYNC_STAGES)) u_rst_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (1'b1),
    .q_o    (rst_sync_n)
  );

  reset_sync #(.STAGES(SYNC_STAGES)) u_ext_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (ext_rst_req_i),
    .q_o    (ext_s)
  );

  state_e                 state_q;
  logic [HOLD_W-1:0]      hold_cnt_q;
  logic [STAGE_W-1:0]     stage_cnt_q;
  logic [IDX_W-1:0]       idx_q;
  logic [NUM_DOMAINS-1:0] dom_rst_q;
  logic                   rst_done_q;
  cause_e                 cause_q;
  logic [WDT_WIDTH-1:0]   wdt_cnt_q, wdt_cnt_d;

  logic   enter_run;
  logic   wdt_req;
  logic   req_any;
  cause_e req_cause;

  assign enter_run = (state_q == ST_RELEASE) && (dom_rst_q == '0);
  assign wdt_req   = (state_q == ST_RUN) && wdt_en_i && (wdt_cnt_q == '0) && !wdt_kick_i;
  assign req_any   = ext_s || sw_rst_req_i || wdt_req;
  assign req_cause = pick_cause(ext_s, wdt_req);

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    wdt_cnt_d = wdt_cnt_q;
    if (enter_run) begin
      wdt_cnt_d = wdt_load_i;
    end else if (state_q == ST_RUN) begin
      if (wdt_kick_i)                        wdt_cnt_d = wdt_load_i;
      else if (wdt_en_i && wdt_cnt_q != '0)  wdt_cnt_d = wdt_cnt_q - WDT_WIDTH'(1);
    end
  end

  // NOTE: the sequencer is cleared by the synchronised reset so assertion stays asynchronous
  // while its first active edge is always clean.
  always_ff @(posedge clk_i or negedge rst_sync_n) begin
    if (!rst_sync_n) wdt_cnt_q <= '0;
    else             wdt_cnt_q <= wdt_cnt_d;
  end

  always_ff @(posedge clk_i or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q     <= ST_ASSERT;
      hold_cnt_q  <= '0;
      stage_cnt_q <= '0;
      idx_q       <= '0;
      dom_rst_q   <= '1;
      rst_done_q  <= 1'b0;
      cause_q     <= CAUSE_POR;
    end else if (req_any) begin
      // A held button keeps re-entering here, pinning hold_cnt at zero until it drops.
      state_q     <= ST_ASSERT;
      hold_cnt_q  <= '0;
      stage_cnt_q <= '0;
      idx_q       <= '0;
      dom_rst_q   <= '1;
      rst_done_q  <= 1'b0;
      cause_q     <= req_cause;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
            state_q     <= ST_RELEASE;
            hold_cnt_q  <= '0;
            stage_cnt_q <= '0;
            idx_q       <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end

        ST_RELEASE: begin
          if (dom_rst_q == '0) begin
            state_q    <= ST_RUN;
            rst_done_q <= 1'b1;
          end else begin
            if (stage_cnt_q == '0) begin
              for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
                if (idx_q == IDX_W'(i)) dom_rst_q[i] <= 1'b0;
              end
            end
            if (stage_cnt_q == STAGE_W'(STAGE_GAP - 1)) begin
              stage_cnt_q <= '0;
              if (idx_q != IDX_W'(NUM_DOMAINS - 1)) idx_q <= idx_q + IDX_W'(1);
            end else begin
              stage_cnt_q <= stage_cnt_q + STAGE_W'(1);
            end
          end
        end

        ST_RUN: rst_done_q <= 1'b1;

        default: state_q <= ST_ASSERT;
      endcase
    end
  end

  assign dom_rst_o   = dom_rst_q;
  assign rst_done_o  = rst_done_q;
  assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_sopc_reset_ctrl.sv
// Directed bench for sopc_reset_ctrl: a per-edge vector table plus hand-written corner sequences.
module tb_sopc_reset_ctrl;

  localparam int SYNC = 2;
  localparam logic [1:0] C_POR = 2'b00, C_EXT = 2'b01, C_SW = 2'b10, C_WDT = 2'b11;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        ext_rst_req_i = 1'b0;
  logic        sw_rst_req_i = 1'b0;
  logic        wdt_en_i = 1'b0;
  logic [15:0] wdt_load_i = 16'd5;
  logic        wdt_kick_i = 1'b0;
  logic [2:0]  dom_rst_o;
  logic        rst_done_o;
  logic [1:0]  rst_cause_o;

  int total = 0;
  int bad   = 0;

  sopc_reset_ctrl #(
    .NUM_DOMAINS (3),
    .HOLD_CYCLES (8),
    .STAGE_GAP   (2),
    .SYNC_STAGES (2),
    .WDT_WIDTH   (16)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .ext_rst_req_i (ext_rst_req_i),
    .sw_rst_req_i  (sw_rst_req_i),
    .wdt_en_i      (wdt_en_i),
    .wdt_load_i    (wdt_load_i),
    .wdt_kick_i    (wdt_kick_i),
    .dom_rst_o     (dom_rst_o),
    .rst_done_o    (rst_done_o),
    .rst_cause_o   (rst_cause_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       sw;
    logic       kick;
    logic       en;
    logic [2:0] dom;
    logic       done;
    logic [1:0] cause;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic sw, input logic kick, input logic en, input logic [2:0] dom,
                     input logic done, input logic [1:0] cause, input int n);
    vec_t v;
    v = '{sw: sw, kick: kick, en: en, dom: dom, done: done, cause: cause};
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Entry i drives inputs before edge i (edge 0 = first edge with synchronised rst high).
  task automatic run_table(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      sw_rst_req_i = vecs[i].sw;
      wdt_kick_i   = vecs[i].kick;
      wdt_en_i     = vecs[i].en;
      tick();
      check($sformatf("tbl[%0d] {dom,done,cause}", i), {26'd0, dom_rst_o, rst_done_o, rst_cause_o},
            {26'd0, vecs[i].dom, vecs[i].done, vecs[i].cause});
    end
    sw_rst_req_i = 1'b0;
    wdt_kick_i   = 1'b0;
    wdt_en_i     = 1'b0;
  endtask

  initial begin
    int n;
    int drops;

    // POR sequence, edges 0..14
    add(0, 0, 0, 3'b111, 0, C_POR, 8);
    add(0, 0, 0, 3'b110, 0, C_POR, 2);
    add(0, 0, 0, 3'b100, 0, C_POR, 2);
    add(0, 0, 0, 3'b000, 0, C_POR, 1);
    add(0, 0, 0, 3'b000, 1, C_POR, 2);
    // SW pulse at edge 15, full re-sequence with the same spacing
    add(1, 0, 0, 3'b111, 0, C_SW, 1);
    add(0, 0, 0, 3'b111, 0, C_SW, 8);
    add(0, 0, 0, 3'b110, 0, C_SW, 2);
    add(0, 0, 0, 3'b100, 0, C_SW, 2);
    add(0, 0, 0, 3'b000, 0, C_SW, 1);
    add(0, 0, 0, 3'b000, 1, C_SW, 1);
    // Watchdog load 5, no kick: five RUN decrements, reset on the sixth edge
    add(0, 0, 1, 3'b000, 1, C_SW, 5);
    add(0, 0, 1, 3'b111, 0, C_WDT, 1);
    add(0, 0, 0, 3'b111, 0, C_WDT, 8);
    add(0, 0, 0, 3'b110, 0, C_WDT, 2);
    add(0, 0, 0, 3'b100, 0, C_WDT, 2);
    add(0, 0, 0, 3'b000, 0, C_WDT, 1);
    add(0, 0, 0, 3'b000, 1, C_WDT, 1);

    #20;
    check("reset_dom", {29'd0, dom_rst_o}, 32'd7);
    check("reset_done", {31'd0, rst_done_o}, 32'd0);
    check("reset_cause", {30'd0, rst_cause_o}, {30'd0, C_POR});
    #30;
    rst_ni = 1'b1;
    repeat (SYNC) tick();
    run_table(0, vecs.size() - 1);

    // Kick every third cycle for 100 cycles: never expires
    drops = 0;
    wdt_en_i = 1'b1;
    for (int c = 0; c < 100; c++) begin
      wdt_kick_i = (c % 3 == 0);
      tick();
      if (rst_done_o !== 1'b1) drops++;
    end
    wdt_kick_i = 1'b0;
    check("kick_no_reset", drops, 0);
    check("kick_cause", {30'd0, rst_cause_o}, {30'd0, C_WDT});

    // Kick coinciding with expiry wins
    wdt_en_i = 1'b0; wdt_kick_i = 1'b1; tick(); wdt_kick_i = 1'b0;
    wdt_en_i = 1'b1;
    repeat (5) tick();
    check("wdt_not_early", {31'd0, rst_done_o}, 32'd1);
    wdt_kick_i = 1'b1; tick(); wdt_kick_i = 1'b0;
    check("kick_vs_expiry", {28'd0, dom_rst_o, rst_done_o}, 32'd1);

    // SW request coinciding with expiry: WDT has priority
    repeat (5) tick();
    check("run_before_coincide", {31'd0, rst_done_o}, 32'd1);
    sw_rst_req_i = 1'b1; tick(); sw_rst_req_i = 1'b0;
    wdt_en_i = 1'b0;
    check("coincide_dom", {29'd0, dom_rst_o}, 32'd7);
    check("coincide_cause", {30'd0, rst_cause_o}, {30'd0, C_WDT});

    // Request edge to rst_done is HOLD + 2*GAP + 2 = 14 edges
    n = 1;
    tick();
    while (rst_done_o !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("restart_latency", n, 14);

    // EXT held 20 cycles during RELEASE
    sw_rst_req_i = 1'b1; tick(); sw_rst_req_i = 1'b0;          // edge t
    check("sw_cause", {30'd0, rst_cause_o}, {30'd0, C_SW});
    repeat (9) tick();                                          // t+9
    check("pre_ext_dom", {29'd0, dom_rst_o}, 32'd6);
    ext_rst_req_i = 1'b1;
    repeat (2) tick();                                          // t+11
    check("ext_sync_delay", {27'd0, dom_rst_o, rst_cause_o}, {27'd0, 3'b100, C_SW});
    tick();                                                     // t+12
    check("ext_assert", {27'd0, dom_rst_o, rst_cause_o}, {27'd0, 3'b111, C_EXT});
    repeat (17) tick();                                         // t+29
    check("ext_hold", {29'd0, dom_rst_o}, 32'd7);
    ext_rst_req_i = 1'b0;
    wdt_load_i = 16'd0;
    wdt_en_i   = 1'b1;
    repeat (10) tick();                                         // t+39
    check("ext_release_wait", {29'd0, dom_rst_o}, 32'd7);
    tick();                                                     // t+40
    check("ext_release", {27'd0, dom_rst_o, rst_cause_o}, {27'd0, 3'b110, C_EXT});

    // wdt_load=0 with wdt_en=1 fires on the first RUN cycle
    repeat (5) tick();                                          // t+45
    check("ext_run", {29'd0, rst_done_o, rst_cause_o}, {29'd0, 1'b1, C_EXT});
    tick();                                                     // t+46
    check("wdt_load_zero", {26'd0, dom_rst_o, rst_done_o, rst_cause_o},
          {26'd0, 3'b111, 1'b0, C_WDT});
    wdt_en_i   = 1'b0;
    wdt_load_i = 16'd5;

    // Mid-sequence POR at edge 9 of the restart
    repeat (10) tick();                                         // edge 9
    check("mid_edge9", {29'd0, dom_rst_o}, 32'd6);
    rst_ni = 1'b0;
    #1;
    check("por_async", {26'd0, dom_rst_o, rst_done_o, rst_cause_o},
          {26'd0, 3'b111, 1'b0, C_POR});
    repeat (3) tick();
    rst_ni = 1'b1;
    repeat (SYNC) tick();
    run_table(0, 14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
